apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 98 +++++++++
 tb/tb_apb_master_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-request host port to APB master bridge
// One transfer in flight; a stalled ACCESS phase is aborted after TIMEOUT cycles.
module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [19:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic        psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  // Ready is withheld during reset so nothing is accepted on the reset edge.
  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 20'h0;
      pwdata    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      wait_cnt  <= 8'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr  <= req_addr;
            pwrite <= req_write;
            pwdata <= req_wdata;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= 8'h0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // pready wins over an expiring wait count in the same cycle.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= pwrite ? 32'h0 : prdata;
            state     <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [19:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);

    // Write, zero wait states
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h06004; req_wdata = 32'hA5A5_0001; pready = 1'b1;
    tick(); req_valid = 1'b0;
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_paddr", paddr, 32'h06004);
    check("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_ready", req_ready, 0);
    tick();
    check("wr_access_psel", psel, 1);
    check("wr_access_penable", penable, 1);
    check("wr_access_rsp", rsp_valid, 0);
    tick();
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_idle_psel", psel, 0);
    check("wr_idle_penable", penable, 0);
    check("wr_idle_ready", req_ready, 1);
    check("wr_idle_paddr_hold", paddr, 32'h06004);
    tick();
    check("wr_rsp_pulse", rsp_valid, 0);

    // Read with 2 wait states; pslverr/prdata during waits must be ignored
    pready = 1'b0; pslverr = 1'b1; prdata = 32'h1111_2222;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h02010;
    tick(); req_valid = 1'b0; req_addr = 20'h0FFFF;
    check("rd_setup_paddr", paddr, 32'h02010);
    check("rd_setup_pwrite", pwrite, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rd_access%0d_psel", i), psel, 1);
      check($sformatf("rd_access%0d_penable", i), penable, 1);
      check($sformatf("rd_access%0d_paddr", i), paddr, 32'h02010);
      check($sformatf("rd_access%0d_rsp", i), rsp_valid, 0);
      if (i == 2) begin
        pready = 1'b1; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
      end
    end
    tick();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err_ignored", rsp_err, 0);
    tick();
    check("rd_rsp_pulse", rsp_valid, 0);
    check("rd_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // Slave error on a read
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h0000_55AA;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h03000;
    tick(); req_valid = 1'b0;
    tick(); tick();
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_rdata", rsp_rdata, 32'h0000_55AA);
    pslverr = 1'b0;
    tick();
    check("err_hold", rsp_err, 1);

    // Timeout with pready held low
    pready = 1'b0; prdata = 32'h1234_5678;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h04000;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_access%0d_psel", i), psel, 1);
      check($sformatf("to_access%0d_rsp", i), rsp_valid, 0);
    end
    tick();
    check("to_psel_drop", psel, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    tick();

    // pready arrives on the 4th ACCESS cycle: normal completion
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h04004;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("late_access%0d_psel", i), psel, 1);
      if (i == 3) begin
        pready = 1'b1; prdata = 32'hCAFE_0004;
      end
    end
    tick();
    check("late_rsp_valid", rsp_valid, 1);
    check("late_rsp_err", rsp_err, 0);
    check("late_rsp_rdata", rsp_rdata, 32'hCAFE_0004);
    tick();

    // Back-to-back reads with req_valid held high
    pready = 1'b1; prdata = 32'hB000_0000;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h0A000;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      check($sformatf("b2b_c%0d_psel", cyc), psel, ((cyc % 3) != 0) ? 1 : 0);
      check($sformatf("b2b_c%0d_rsp", cyc), rsp_valid, ((cyc % 3) == 0) ? 1 : 0);
      if ((cyc % 3) == 0)
        check($sformatf("b2b_c%0d_rdata", cyc), rsp_rdata, 32'hB000_0000 + 32'(cyc / 3 - 1));
      if ((cyc % 3) == 1) begin
        check($sformatf("b2b_c%0d_paddr", cyc), paddr, 32'h0A000 + 32'((cyc / 3) * 4));
        prdata = 32'hB000_0000 + 32'(cyc / 3);
        req_addr = 20'h0A000 + 20'(((cyc / 3) + 1) * 4);
        if (cyc / 3 == 2) req_valid = 1'b0;
      end
    end
    tick();
    check("b2b_end_psel", psel, 0);
    check("b2b_end_rsp", rsp_valid, 0);

    // Reset during a read wait state
    pready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h05000;
    tick(); req_valid = 1'b0;
    tick(); tick();
    check("rstmid_psel_before", psel, 1);
    rst = 1'b1;
    #1;
    check("rstmid_ready", req_ready, 0);
    tick();
    check("rstmid_psel", psel, 0);
    check("rstmid_penable", penable, 0);
    check("rstmid_paddr", paddr, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_rsp_rdata", rsp_rdata, 0);
    check("rstmid_rsp_err", rsp_err, 0);
    rst = 1'b0;
    #1;
    check("rstmid_ready_after", req_ready, 1);
    tick();
    check("rstmid_no_rsp", rsp_valid, 0);
    check("rstmid_idle_psel", psel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
